// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default widths and port-slice helper for the multiport register file
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    function automatic int portOffset(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - register file access bus: clear request, write port, read ports, external slot
interface regfile_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) ();
    logic                     clear_req;
    logic                     busy;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W-1:0]        ext_data;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;

    modport master (
        output clear_req, we, waddr, wdata, ext_data, raddr,
        input  busy, rdata
    );

    modport slave (
        input  clear_req, we, waddr, wdata, ext_data, raddr,
        output busy, rdata
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine; walks every entry once after reset or clear_req
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    rf_state_t         state, stateNext;
    logic [ADDR_W-1:0] clr_cnt, clrCntNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= stateNext;
            clr_cnt <= clrCntNext;
        end
    end

    // The counter holds at LAST on exit; it is reloaded on the next clear request.
    always_comb begin
        stateNext  = state;
        clrCntNext = clr_cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    stateNext  = CLEAR;
                    clrCntNext = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST) stateNext = IDLE;
                else                 clrCntNext = clr_cnt + 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        clr_we   = (state == CLEAR);
        clr_addr = clr_cnt;
    end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NUM_RD-read/1-write register file with external slot; REGFILE_BYPASS_EN selects write-first reads
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = 2,
    parameter int EXT_REG = 9
) (
    input logic                clk,
    input logic                rst,
    regfile_multiport_if.slave bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] EXT_ADDR = ADDR_W'(EXT_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wrAccept;
    logic [ADDR_W-1:0] raddrA [NUM_RD];
    logic [DATA_W-1:0] rdNext [NUM_RD];
    logic [DATA_W-1:0] rdQ    [NUM_RD];

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (bus.clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign bus.busy = busy;
    assign wrAccept = bus.we && !busy && !rst && (bus.waddr != EXT_ADDR);

    always_ff @(posedge clk) begin
        if (clr_we)        mem[clr_addr]  <= '0;
        else if (wrAccept) mem[bus.waddr] <= bus.wdata;
    end

    // The external slot always wins, so a write-first bypass can never shadow it.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            raddrA[i] = bus.raddr[portOffset(i, ADDR_W) +: ADDR_W];
            if (raddrA[i] == EXT_ADDR)
                rdNext[i] = bus.ext_data;
`ifdef REGFILE_BYPASS_EN
            else if (wrAccept && (raddrA[i] == bus.waddr))
                rdNext[i] = bus.wdata;
`endif
            else
                rdNext[i] = mem[raddrA[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst || busy) rdQ[i] <= '0;
            else             rdQ[i] <= rdNext[i];
        end
    end

    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NUM_RD; i++)
            bus.rdata[portOffset(i, DATA_W) +: DATA_W] = rdQ[i];
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for regfile_multiport; expectations follow REGFILE_BYPASS_EN
module tb_regfile_multiport;

    typedef struct {
        string       name;
        bit          chkBusy;
        bit          expBusy;
        bit          chk0;
        logic [31:0] exp0;
        bit          chk1;
        logic [31:0] exp1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus ();

    regfile_multiport #(
        .DATA_W  (32),
        .ADDR_W  (4),
        .NUM_RD  (2),
        .EXT_REG (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic setRd(input logic [3:0] a0, input logic [3:0] a1);
        bus.raddr = {a1, a0};
    endtask

    task automatic setWr(input logic w, input logic [3:0] a, input logic [31:0] d);
        bus.we    = w;
        bus.waddr = a;
        bus.wdata = d;
    endtask

    // Advance one clock edge and queue what the outputs must show after it.
    task automatic cyc(input string nm, input bit cb, input bit eb,
                       input bit c0, input logic [31:0] e0,
                       input bit c1, input logic [31:0] e1);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = nm; e.chkBusy = cb; e.expBusy = eb;
        e.chk0 = c0; e.exp0 = e0; e.chk1 = c1; e.exp1 = e1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chkBusy) begin
                nChecks++;
                if (bus.busy !== e.expBusy) begin
                    nFail++;
                    $display("FAIL %s busy got %b expected %b", e.name, bus.busy, e.expBusy);
                end
            end
            if (e.chk0) begin
                nChecks++;
                if (bus.rdata[31:0] !== e.exp0) begin
                    nFail++;
                    $display("FAIL %s rdata0 got %h expected %h", e.name, bus.rdata[31:0], e.exp0);
                end
            end
            if (e.chk1) begin
                nChecks++;
                if (bus.rdata[63:32] !== e.exp1) begin
                    nFail++;
                    $display("FAIL %s rdata1 got %h expected %h", e.name, bus.rdata[63:32], e.exp1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout, stimulus did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] collExp;
        rst           = 1'b1;
        bus.clear_req = 1'b0;
        bus.ext_data  = 32'h0;
        setWr(1'b0, 4'd0, 32'h0);
        setRd(4'd0, 4'd0);

        // Reset and initial clear: 16 busy cycles counting the reset edge.
        cyc("reset", 1, 1, 1, 32'h0, 1, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) cyc("init_busy", 1, 1, 1, 32'h0, 1, 32'h0);
        cyc("init_done", 1, 0, 1, 32'h0, 1, 32'h0);
        for (int i = 0; i < 16; i++) begin
            setRd(4'(i), 4'(15 - i));
            cyc("init_zero", 1, 0, 1, 32'h0, 1, 32'h0);
        end

        // Write then read.
        setRd(4'd0, 4'd0);
        setWr(1'b1, 4'd2, 32'hA5A5_A5A5);
        cyc("wr_r2", 1, 0, 1, 32'h0, 1, 32'h0);
        setWr(1'b0, 4'd0, 32'h0);
        setRd(4'd2, 4'd0);
        cyc("rd_r2", 0, 0, 1, 32'hA5A5_A5A5, 1, 32'h0);

        // External slot: storage write dropped, reads follow ext_data.
        bus.ext_data = 32'h1234_5678;
        setWr(1'b1, 4'd9, 32'hDEAD_BEEF);
        setRd(4'd9, 4'd9);
        cyc("ext_wr", 0, 0, 1, 32'h1234_5678, 1, 32'h1234_5678);
        setWr(1'b0, 4'd0, 32'h0);
        cyc("ext_hold", 0, 0, 1, 32'h1234_5678, 1, 32'h1234_5678);
        bus.ext_data = 32'h1;
        cyc("ext_follow", 0, 0, 1, 32'h1, 1, 32'h1);

        // Same-cycle write/read collision on r3.
        setWr(1'b1, 4'd3, 32'h11);
        setRd(4'd2, 4'd0);
        cyc("pre_r3", 0, 0, 0, 32'h0, 0, 32'h0);
`ifdef REGFILE_BYPASS_EN
        collExp = 32'h55;
`else
        collExp = 32'h11;
`endif
        setWr(1'b1, 4'd3, 32'h55);
        setRd(4'd2, 4'd3);
        cyc("collide", 0, 0, 1, 32'hA5A5_A5A5, 1, collExp);
        setWr(1'b0, 4'd0, 32'h0);
        cyc("after_collide", 0, 0, 0, 32'h0, 1, 32'h55);

        // Mid-run clear with writes attempted while busy.
        for (int i = 1; i <= 4; i++) begin
            setWr(1'b1, 4'(i), 32'(i));
            cyc("fill", 0, 0, 0, 32'h0, 0, 32'h0);
        end
        setWr(1'b0, 4'd0, 32'h0);
        setRd(4'd1, 4'd4);
        cyc("fill_chk", 1, 0, 1, 32'h1, 1, 32'h4);
        bus.clear_req = 1'b1;
        cyc("clr_start", 1, 1, 1, 32'h1, 1, 32'h4);
        bus.clear_req = 1'b0;
        setWr(1'b1, 4'd5, 32'h0000_0BAD);
        for (int i = 0; i < 15; i++) begin
            bus.clear_req = (i == 4);
            cyc("clr_busy", 1, 1, 1, 32'h0, 1, 32'h0);
        end
        bus.clear_req = 1'b0;
        cyc("clr_done", 1, 0, 1, 32'h0, 1, 32'h0);
        setWr(1'b0, 4'd0, 32'h0);
        cyc("clr_r1r4", 1, 0, 1, 32'h0, 1, 32'h0);
        setRd(4'd2, 4'd3);
        cyc("clr_r2r3", 0, 0, 1, 32'h0, 1, 32'h0);
        setRd(4'd5, 4'd5);
        cyc("busy_wr_dropped", 0, 0, 1, 32'h0, 1, 32'h0);

        // Reset at clear cycle 7 restarts the full 16-cycle walk.
        setWr(1'b1, 4'd7, 32'h77);
        cyc("wr_r7", 0, 0, 0, 32'h0, 0, 32'h0);
        setWr(1'b0, 4'd0, 32'h0);
        setRd(4'd7, 4'd7);
        cyc("rd_r7", 0, 0, 1, 32'h77, 1, 32'h77);
        bus.clear_req = 1'b1;
        cyc("clr2_start", 1, 1, 0, 32'h0, 0, 32'h0);
        bus.clear_req = 1'b0;
        for (int i = 0; i < 6; i++) cyc("clr2_busy", 1, 1, 1, 32'h0, 1, 32'h0);
        rst = 1'b1;
        cyc("clr2_rst", 1, 1, 1, 32'h0, 1, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) cyc("rst_busy", 1, 1, 1, 32'h0, 1, 32'h0);
        cyc("rst_done", 1, 0, 1, 32'h0, 1, 32'h0);
        cyc("r7_zero", 1, 0, 1, 32'h0, 1, 32'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        nChecks++;
        if (sb.size() != 0) begin
            nFail++;
            $display("FAIL drain scoreboard entries left %0d expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
